i2s_rx_sampler: RTL

Serial audio front end feeding the 32-tap serial FIR.
- Receives an I2S (or left-justified) stream on asynchronous sclk/lrclk/sdata pins.
- Extracts one channel and presents a 16-bit two's-complement word on xOut with a one-clk sample strobe.
- Enforces a minimum spacing between strobes so the FIR's 32-cycle MAC sweep always completes.

---
 rtl/i2s_rx_sampler.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/i2s_rx_sampler.sv
// I2S / left-justified serial receiver: extracts one channel as a 16-bit word with a
// spaced one-clk strobe. Build option LEFT_JUSTIFIED_EN removes the one-bit MSB delay.
module i2s_rx_sampler #(
  parameter int CHANNEL  = 0,
  parameter int MIN_GAP  = 34,
  parameter int GAP_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk_in,
  input  logic        lrclk_in,
  input  logic        sdata_in,
  input  logic        clr_flags,
  output logic [15:0] xOut,
  output logic        sample,
  output logic        overrun,
  output logic        frame_err
);

  localparam logic                CH_SEL   = (CHANNEL != 0);
  localparam logic [GAP_BITS-1:0] GAP_MAX  = GAP_BITS'(MIN_GAP);
  localparam logic [GAP_BITS-1:0] GAP_ONE  = GAP_BITS'(1);
  localparam int                  SYNC_W   = 3;
  localparam int                  IDX_SCLK = 2;
  localparam int                  IDX_LR   = 1;
  localparam int                  IDX_SD   = 0;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHIFT,
    HOLD
  } state_t;

  logic [SYNC_W-1:0] pin_raw;
  logic [SYNC_W-1:0] pin_sync;

  assign pin_raw = {sclk_in, lrclk_in, sdata_in};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_W; gi++) begin : g_sync
      logic meta_q;
      logic sync_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
        end else begin
          meta_q <= pin_raw[gi];
          sync_q <= meta_q;
        end
      end
      assign pin_sync[gi] = sync_q;
    end
  endgenerate

  logic                sclk_prev_q;
  logic                lr_last_q, lr_last_d;
  state_t              state_q, state_d;
  logic [15:0]         shift_q, shift_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [GAP_BITS-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]         xout_q, xout_d;
  logic                sample_q, sample_d;
  logic                overrun_q, overrun_d;
  logic                frame_err_q, frame_err_d;

  logic bit_evt;
  logic lr_now;
  logic sd_now;
  logic lr_edge;
  logic sel_edge;
  logic word_done;
  logic short_word;
  logic eval_edge;
  logic gap_ok;
  logic accept;

  assign bit_evt  = pin_sync[IDX_SCLK] & ~sclk_prev_q;
  assign lr_now   = pin_sync[IDX_LR];
  assign sd_now   = pin_sync[IDX_SD];
  assign lr_edge  = bit_evt & (lr_now != lr_last_q);
  assign sel_edge = lr_edge & (lr_now == CH_SEL);

  // Bit-level FSM: everything here only moves on a synchronised sclk rising edge.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    word_done  = 1'b0;
    short_word = 1'b0;
    eval_edge  = 1'b0;

    if (bit_evt) begin
      case (state_q)
        IDLE, HOLD: begin
          eval_edge = lr_edge;
        end
        DELAY: begin
          if (lr_edge) begin
            eval_edge = 1'b1;
          end else begin
            shift_d = {shift_q[14:0], sd_now};
            cnt_d   = 4'd1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (lr_edge && (cnt_q != 4'd15)) begin
            short_word = 1'b1;
            eval_edge  = 1'b1;
          end else begin
            // The last bit of a full-width slot arrives together with the lr edge.
            shift_d   = {shift_q[14:0], sd_now};
            eval_edge = lr_edge;
            if (cnt_q == 4'd15) begin
              word_done = 1'b1;
              cnt_d     = 4'd0;
              state_d   = HOLD;
            end else begin
              cnt_d   = cnt_q + 4'd1;
              state_d = SHIFT;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase

      if (eval_edge) begin
        if (sel_edge) begin
`ifdef LEFT_JUSTIFIED_EN
          shift_d = {shift_q[14:0], sd_now};
          cnt_d   = 4'd1;
          state_d = SHIFT;
`else
          cnt_d   = 4'd0;
          state_d = DELAY;
`endif
        end else begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
    end
  end

  assign gap_ok = (gap_cnt_q >= GAP_MAX);
  assign accept = word_done & gap_ok;

  always_comb begin
    lr_last_d   = bit_evt ? lr_now : lr_last_q;
    sample_d    = accept;
    xout_d      = accept ? shift_d : xout_q;
    gap_cnt_d   = gap_cnt_q;
    if (accept) begin
      gap_cnt_d = '0;
    end else if (gap_cnt_q < GAP_MAX) begin
      gap_cnt_d = gap_cnt_q + GAP_ONE;
    end
    // Flag set takes priority over a same-cycle clear.
    overrun_d   = (word_done & ~gap_ok) | (overrun_q & ~clr_flags);
    frame_err_d = short_word | (frame_err_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_prev_q <= 1'b0;
      lr_last_q   <= 1'b0;
      state_q     <= IDLE;
      shift_q     <= 16'h0000;
      cnt_q       <= 4'd0;
      gap_cnt_q   <= GAP_MAX;
      xout_q      <= 16'h0000;
      sample_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_prev_q <= pin_sync[IDX_SCLK];
      lr_last_q   <= lr_last_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      xout_q      <= xout_d;
      sample_q    <= sample_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign xOut      = xout_q;
  assign sample    = sample_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
